fsm_input_guard: RTL and testbench

//  Upstream stage of the 3-bit user-driven FSM. Qualifies raw user commands by debouncing,

---
 rtl/fsm_input_guard_pkg.sv | 23 ++
 rtl/fsm_input_guard_debounce.sv | 58 +++++
 rtl/fsm_input_guard.sv | 133 +++++++++++++
 tb/tb_fsm_input_guard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_input_guard_pkg.sv
// Shared definitions for the input guard: state encodings, default width and
// the legal-transition rule reused by the downstream FSM checker.
package fsm_input_guard_pkg;

  localparam int W_DEFAULT = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_DECIDE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // Operands are zero-extended to 32 bits so one function serves any width w.
  function automatic logic is_legal(input logic [31:0] cur, input logic [31:0] cand,
                                    input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (cand == 32'd0) || (cand == cur) ||
           (cand == ((cur + 32'd1) & mask)) ||
           ((cur != 32'd0) && (cand == cur - 32'd1));
  endfunction

endpackage

// File: rtl/fsm_input_guard_debounce.sv
// Debouncer: qualifies a command once it has been seen valid and unchanged for
// STABLE_CYCLES consecutive samples; only runs while en_i is high.
module fsm_input_guard_debounce #(
  parameter int W             = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         raw_valid_i,
  input  logic [W-1:0] raw_cmd_i,
  output logic         qual_o,
  output logic [W-1:0] cand_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic          active_q, active_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;

  always_comb begin
    active_d = 1'b0;
    cand_d   = cand_q;
    stab_d   = '0;
    qual_o   = 1'b0;
    if (en_i && raw_valid_i) begin
      if (active_q && (raw_cmd_i == cand_q)) begin
        stab_d = stab_q + SW'(1);
      end else begin
        cand_d = raw_cmd_i;
        stab_d = SW'(1);
      end
      // cand is frozen after qualification so the decide stage reads it next cycle.
      if (stab_d == SW'(STABLE_CYCLES)) begin
        qual_o = 1'b1;
        stab_d = '0;
      end else begin
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cand_q   <= '0;
      stab_q   <= '0;
    end else begin
      active_q <= active_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
    end
  end

  assign cand_o = cand_q;

endmodule

// File: rtl/fsm_input_guard.sv
// Input guard for the user-driven FSM: debounces raw commands, applies the
// legal-transition rule, and locks the FSM to state 0 after repeated rejects.
module fsm_input_guard
  import fsm_input_guard_pkg::*;
#(
  parameter int W             = W_DEFAULT,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_ERR       = 3,
  parameter int LOCK_CYCLES   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             raw_valid,
  input  logic [W-1:0]                     raw_cmd,
  output logic [W-1:0]                     user_input,
  output logic                             cmd_accept,
  output logic                             cmd_reject,
  output logic                             locked,
  output logic [$clog2(MAX_ERR+1)-1:0]     err_cnt
);

  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  user_q, user_d;
  logic          acc_q, acc_d;
  logic          rej_q, rej_d;
  logic          locked_q, locked_d;
  logic [EW-1:0] err_q, err_d, err_inc;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          deb_en, qual;
  logic [W-1:0]  cand;

  assign deb_en = (state_q == ST_IDLE) || (state_q == ST_SETTLE);

  fsm_input_guard_debounce #(
    .W             (W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (deb_en),
    .raw_valid_i (raw_valid),
    .raw_cmd_i   (raw_cmd),
    .qual_o      (qual),
    .cand_o      (cand)
  );

  always_comb begin
    state_d    = state_q;
    user_d     = user_q;
    acc_d      = 1'b0;
    rej_d      = 1'b0;
    locked_d   = locked_q;
    err_d      = err_q;
    lock_cnt_d = lock_cnt_q;
    err_inc    = err_q + EW'(1);
    case (state_q)
      ST_IDLE: begin
        if (raw_valid) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (qual)            state_d = ST_DECIDE;
        else if (!raw_valid) state_d = ST_IDLE;
      end
      ST_DECIDE: begin
        if (is_legal(32'(user_q), 32'(cand), W)) begin
          user_d  = cand;
          acc_d   = 1'b1;
          err_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          rej_d      = 1'b1;
          err_d      = err_inc;
          lock_cnt_d = '0;
          state_d    = (err_inc == EW'(MAX_ERR)) ? ST_LOCKOUT : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!raw_valid) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        // locked rises one cycle after the reject pulse so the two never overlap.
        if (!locked_q) begin
          locked_d   = 1'b1;
          user_d     = '0;
          lock_cnt_d = LW'(1);
        end else if (lock_cnt_q == LW'(LOCK_CYCLES)) begin
          locked_d   = 1'b0;
          err_d      = '0;
          lock_cnt_d = '0;
          state_d    = ST_RELEASE;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: begin
        state_d    = ST_LOCKOUT;
        user_d     = '0;
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      user_q     <= '0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      user_q     <= user_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign user_input = user_q;
  assign cmd_accept = acc_q;
  assign cmd_reject = rej_q;
  assign locked     = locked_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_fsm_input_guard.sv
// Scoreboard bench for fsm_input_guard: directed scenarios then randomized
// command bursts, checked against a timeline model of the guard's rules.
module tb_fsm_input_guard;

  localparam int W     = 3;
  localparam int STAB  = 4;
  localparam int MAXE  = 3;
  localparam int LOCKC = 16;

  logic         clk;
  logic         rst_n;
  logic         raw_valid;
  logic [W-1:0] raw_cmd;
  logic [W-1:0] user_input;
  logic         cmd_accept;
  logic         cmd_reject;
  logic         locked;
  logic [1:0]   err_cnt;

  fsm_input_guard #(
    .W             (W),
    .STABLE_CYCLES (STAB),
    .MAX_ERR       (MAXE),
    .LOCK_CYCLES   (LOCKC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_valid  (raw_valid),
    .raw_cmd    (raw_cmd),
    .user_input (user_input),
    .cmd_accept (cmd_accept),
    .cmd_reject (cmd_reject),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit acc;
    int due;
  } exp_t;
  exp_t q[$];

  int vecs = 0;
  int miscmp = 0;
  int cyc = 0;
  bit started = 0;

  // Model view of the outputs after the most recent clock edge.
  int m_user = 0, m_err = 0;
  bit m_locked = 0;
  // Timeline bookkeeping: run of identical valid samples, pending decision,
  // pending/ongoing lockout, and the "must see raw_valid low" gate.
  int run = 0, run_cmd = 0, lock_shown = 0;
  bit deciding = 0, lock_pending = 0, wait_low = 0;

  function automatic bit legal(int cur, int cand);
    return (cand == 0) || (cand == cur) || (cand == (cur + 1) % 8) ||
           (cur > 0 && cand == cur - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: one step per rising edge on the inputs present at that edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        started = 1;
        m_user = 0; m_err = 0; m_locked = 0;
        run = 0; lock_shown = 0;
        deciding = 0; lock_pending = 0; wait_low = 0;
      end else if (started) begin
        if (lock_pending) begin
          lock_pending = 0;
          m_locked = 1;
          m_user = 0;
          lock_shown = 1;
        end else if (m_locked) begin
          if (lock_shown == LOCKC) begin
            m_locked = 0;
            m_err = 0;
            wait_low = 1;
          end else begin
            lock_shown++;
          end
        end else if (deciding) begin
          deciding = 0;
          wait_low = 1;
          if (legal(m_user, run_cmd)) begin
            m_user = run_cmd;
            m_err = 0;
            q.push_back('{acc: 1'b1, due: cyc});
          end else begin
            m_err++;
            q.push_back('{acc: 1'b0, due: cyc});
            if (m_err == MAXE) lock_pending = 1;
          end
        end else if (wait_low) begin
          if (!raw_valid) wait_low = 0;
        end else begin
          if (!raw_valid) run = 0;
          else if (run > 0 && int'(raw_cmd) == run_cmd) run++;
          else begin
            run_cmd = int'(raw_cmd);
            run = 1;
          end
          if (run == STAB) begin
            deciding = 1;
            run = 0;
          end
        end
      end
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("user_input", 32'(user_input), 32'(m_user));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("pulse_exclusive", 32'(cmd_accept & cmd_reject), 32'd0);
        if (cmd_accept || cmd_reject) begin
          if (q.size() == 0) begin
            chk("spurious_pulse", 32'({cmd_accept, cmd_reject}), 32'd0);
          end else begin
            e = q.pop_front();
            chk("pulse_kind_accept", 32'(cmd_accept), 32'(e.acc));
            chk("pulse_cycle", 32'(cyc), 32'(e.due));
          end
        end else if (q.size() != 0) begin
          e = q.pop_front();
          chk("missing_pulse", 32'({cmd_accept, cmd_reject}), e.acc ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic drive(input bit v, input int c, input int n);
    raw_valid = v;
    raw_cmd   = W'(c);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request: held valid for STAB samples, then released.
  task automatic request(input int c);
    drive(1, c, STAB);
    drive(0, 0, 3);
  endtask

  initial begin
    int c1, c2, pick;
    rst_n = 1'b0;
    raw_valid = 1'b0;
    raw_cmd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 2);

    // Basic accept 0->1, then debounce restart 1,1,2,2,2,2 accepted as 2.
    request(1);
    drive(1, 1, 2);
    drive(1, 2, 4);
    drive(0, 0, 3);

    // Three illegal requests from 2 -> rejects, then lockout.
    request(5);
    request(5);
    request(5);
    drive(0, 0, 22);

    // Climb to 3 and hold it long: a single accept.
    request(1);
    request(2);
    drive(1, 3, 24);
    drive(0, 0, 3);

    // Climb to 7, wrap to 0 accepted, then 0->7 rejected.
    request(4);
    request(5);
    request(6);
    request(7);
    request(0);
    request(7);

    // Reset mid-SETTLE, then mid-LOCKOUT.
    drive(1, 4, 2);
    do_reset();
    drive(0, 0, 2);
    request(5);
    request(5);
    request(5);
    drive(0, 0, 6);
    do_reset();
    drive(0, 0, 2);
    request(1);

    // Randomized bursts, biased toward neighbouring values.
    repeat (300) begin
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      c1 = (m_user + 1) % 8;
      else if (pick == 1) c1 = (m_user + 7) % 8;
      else                c1 = int'($urandom_range(0, 7));
      c2 = int'($urandom_range(0, 7));
      drive(1, c1, int'($urandom_range(1, 7)));
      if ($urandom_range(0, 3) == 0) drive(1, c2, int'($urandom_range(1, 6)));
      drive(0, 0, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 80) == 0) do_reset();
    end

    drive(0, 0, 30);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
